// File: rtl/membus_arb_pkg.sv
// Shared types and helpers for the N-master memory-bus arbiter.
package membus_arb_pkg;

  localparam int unsigned XLEN              = 32;
  localparam int unsigned MEMBUS_DATA_WIDTH = 32;

  typedef enum logic {
    FIXED = 1'b0,
    RR    = 1'b1
  } arb_mode_e;

  // Master ID width; a single master still needs one bit to carry an ID.
  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/arb_id_fifo.sv
// In-order FIFO of granted master IDs used to route slave responses back.
module arb_id_fifo #(
  parameter int unsigned ID_W  = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [ID_W-1:0]          i_id,
  input  logic                     i_pop,
  output logic [ID_W-1:0]          o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SLOTS = 1 << PW;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic [ID_W-1:0] r_mem [SLOTS];
  logic [PW-1:0]   r_wr;
  logic [PW-1:0]   r_rd;
  logic [CW-1:0]   r_count;
  logic            w_push;
  logic            w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  // ID storage; contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_id;
  end

  // Pointers wrap at DEPTH; occupancy is tracked in its own counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= (r_wr == PW'(DEPTH - 1)) ? '0 : r_wr + PW'(1);
      if (w_pop)  r_rd <= (r_rd == PW'(DEPTH - 1)) ? '0 : r_rd + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/membus_arbiter_n.sv
// N-master to single-slave memory-bus arbiter with grant lock and in-order response routing.
module membus_arbiter_n
  import membus_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS     = 2,
  parameter int unsigned ADDR_WIDTH      = XLEN,
  parameter int unsigned DATA_WIDTH      = MEMBUS_DATA_WIDTH,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned RR_MODE         = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_MASTERS-1:0]              m_valid,
  output logic [NUM_MASTERS-1:0]              m_ready,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_addr,
  input  logic [NUM_MASTERS-1:0]              m_wen,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_wdata,
  input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_wmask,
  output logic [NUM_MASTERS-1:0]              m_rvalid,
  output logic [DATA_WIDTH-1:0]               m_rdata,
  output logic                                s_valid,
  input  logic                                s_ready,
  output logic [ADDR_WIDTH-1:0]               s_addr,
  output logic                                s_wen,
  output logic [DATA_WIDTH-1:0]               s_wdata,
  output logic [DATA_WIDTH/8-1:0]             s_wmask,
  input  logic                                s_rvalid,
  input  logic [DATA_WIDTH-1:0]               s_rdata,
  output logic [$clog2(MAX_OUTSTANDING):0]    outstanding,
  output logic                                err_orphan
);

  localparam int unsigned IW   = id_width(NUM_MASTERS);
  localparam int unsigned MW   = DATA_WIDTH / 8;
  localparam arb_mode_e   MODE = (RR_MODE != 0) ? RR : FIXED;

  logic          r_lock;
  logic [IW-1:0] r_grant;
  logic [IW-1:0] r_rr_ptr;
  logic          r_err_orphan;
  logic [IW-1:0] w_base;
  logic [IW-1:0] w_arb_grant;
  logic [IW-1:0] w_grant;
  logic          w_found;
  logic          w_full;
  logic          w_empty;
  logic          w_s_valid;
  logic          w_issue;
  logic [IW-1:0] w_head;

  // Fixed priority is a round-robin search that always starts just after the last index.
  assign w_base = (MODE == RR) ? r_rr_ptr : IW'(NUM_MASTERS - 1);

  // Pick the first requester after w_base, wrapping modulo NUM_MASTERS.
  always_comb begin
    w_arb_grant = '0;
    w_found     = 1'b0;
    for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
        if (!w_found && m_valid[i] && (((32'(w_base) + k) % NUM_MASTERS) == i)) begin
          w_arb_grant = IW'(i);
          w_found     = 1'b1;
        end
      end
    end
  end

  assign w_grant   = r_lock ? r_grant : w_arb_grant;
  assign w_s_valid = rst && (|m_valid) && !w_full;
  assign w_issue   = w_s_valid && s_ready;
  assign s_valid   = w_s_valid;
  assign m_rdata   = s_rdata;
  assign err_orphan = r_err_orphan;

  // Route the granted master's payload to the slave and its handshake back.
  always_comb begin
    s_addr  = '0;
    s_wdata = '0;
    s_wmask = '0;
    s_wen   = 1'b0;
    m_ready = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (w_grant == IW'(i)) begin
        s_addr     = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        s_wdata    = m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        s_wmask    = m_wmask[i*MW +: MW];
        s_wen      = m_wen[i] && w_s_valid;
        m_ready[i] = w_issue;
      end
    end
  end

  // Steer each slave response to the master at the head of the ID FIFO.
  always_comb begin
    m_rvalid = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      m_rvalid[i] = rst && s_rvalid && !w_empty && (w_head == IW'(i));
    end
  end

  // Grant lock holds a stalled request steady; rr_ptr moves only on issue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lock       <= 1'b0;
      r_grant      <= '0;
      r_rr_ptr     <= IW'(NUM_MASTERS - 1);
      r_err_orphan <= 1'b0;
    end else begin
      if (w_issue) begin
        r_lock   <= 1'b0;
        r_rr_ptr <= w_grant;
      end else if (w_s_valid) begin
        r_lock  <= 1'b1;
        r_grant <= w_grant;
      end
      if (s_rvalid && w_empty) r_err_orphan <= 1'b1;
    end
  end

  arb_id_fifo #(
    .ID_W  (IW),
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_issue),
    .i_id    (w_grant),
    .i_pop   (s_rvalid),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (outstanding)
  );

endmodule

// File: doc/membus_arbiter_n.md
Name: membus_arbiter_n

Overview:
- N-master to 1-slave memory-bus arbiter that replaces the hard-wired I/D mux in front of the MMIO controller.
- Supports 2..8 masters (fetch, data, later DMA/debug) with a selectable fixed-priority or round-robin mode.
- Supports up to MAX_OUTSTANDING pipelined in-flight requests. Responses are routed back by an in-order ID FIFO rather than a single last-owner bit.

Parameters:
- NUM_MASTERS, 2: number of requesting masters, legal 2..8.
- ADDR_WIDTH, XLEN: request address width.
- DATA_WIDTH, MEMBUS_DATA_WIDTH: request and response data width.
- MAX_OUTSTANDING, 4: depth of the response-routing FIFO; a power of two, 1..16.
- RR_MODE, 1: 1 = round-robin; 0 = fixed priority, where the lowest index wins.

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset, asynchronous, active-low.
- m_valid, in, NUM_MASTERS: per-master request valid.
- m_ready, out, NUM_MASTERS: per-master request accepted.
- m_addr, in, NUM_MASTERS*ADDR_WIDTH: packed request addresses; master i occupies slice i.
- m_wen, in, NUM_MASTERS: write enable.
- m_wdata, in, NUM_MASTERS*DATA_WIDTH: write data.
- m_wmask, in, NUM_MASTERS*(DATA_WIDTH/8): byte write mask.
- m_rvalid, out, NUM_MASTERS: per-master response valid.
- m_rdata, out, DATA_WIDTH: response data, broadcast to all masters.
- s_valid, out, 1: slave request valid.
- s_ready, in, 1: slave request accepted.
- s_addr, out, ADDR_WIDTH: slave request address.
- s_wen, out, 1: slave write enable.
- s_wdata, out, DATA_WIDTH: slave write data.
- s_wmask, out, DATA_WIDTH/8: slave byte write mask.
- s_rvalid, in, 1: slave response valid; one response per accepted request, reads and writes, in order.
- s_rdata, in, DATA_WIDTH: slave response data.
- outstanding, out, $clog2(MAX_OUTSTANDING)+1: current FIFO occupancy.
- err_orphan, out, 1: sticky flag for a response with no tracked owner.

Behaviour:
- Handshake: masters hold m_valid and payload stable until m_ready. An issue occurs when s_valid && s_ready.
- Grant logic, combinational, evaluated only when the grant is not locked:
  - RR_MODE=1: search from rr_ptr+1 modulo NUM_MASTERS; the first requester wins.
  - RR_MODE=0: the lowest requesting index wins.
- Grant lock register: set when s_valid && !s_ready. While it is set, the granted index is frozen and s_* payload stays stable. It clears on issue.
- s_valid = (OR of m_valid) && !fifo_full. When s_valid=0, s_addr/s_wdata/s_wmask are don't-care and s_wen=0.
- m_ready[i] = s_ready && s_valid && (grant==i). All other m_ready bits are 0.
- rr_ptr updates to the granted index on each issue only. Reset value is NUM_MASTERS-1, so master 0 wins first.
- Response-routing FIFO, ID width max(1,$clog2(NUM_MASTERS)):
  - Push the granted ID on issue.
  - Pop on s_rvalid when the FIFO is non-empty.
  - m_rvalid[head_id] = s_rvalid; all other bits 0.
  - m_rdata = s_rdata, combinational, zero-latency pass-through.
- FIFO full: no issue, even if a pop occurs in the same cycle. Issue resumes the next cycle. Occupancy never exceeds MAX_OUTSTANDING.
- Simultaneous push and pop when non-empty: occupancy is unchanged and the pointers both advance.
- s_rvalid with the FIFO empty: response dropped, all m_rvalid=0, err_orphan<=1. A same-cycle push does not satisfy it, because slave latency is at least 1.
- Pointers wrap modulo MAX_OUTSTANDING. Occupancy is a separate counter.
- Reset values:
  - Registers: FIFO empty, outstanding=0, err_orphan=0, lock=0, rr_ptr=NUM_MASTERS-1.
  - Outputs: m_ready=0, m_rvalid=0, s_valid=0 while rst is low.
- Reset mid-operation: in-flight IDs are discarded. Any later stale response sets err_orphan, so the slave must be reset together with the arbiter.
- err_orphan clears only on reset.

Decomposition:
- Package membus_arb_pkg: arb_mode_e (FIXED, RR) and function id_width(n).
- Sub-module arb_id_fifo (ID-width FIFO with push/pop/full/empty/count), instantiated once.
- Grant logic and lock stay in the top-level module.

Test Plan:
- NUM_MASTERS=2, RR: both masters request continuously, s_ready=1, slave latency 1 → grants alternate 0,1,0,1; each m_rvalid arrives 1 cycle after its m_ready with the matching rdata.
- RR_MODE=0, 3 masters all requesting → master 0 is always granted; masters 1 and 2 are granted only when m_valid[0]=0.
- s_ready=0 for 3 cycles while master 1 is granted, then master 0 raises valid → grant stays on 1 and payload is stable until issue.
- MAX_OUTSTANDING=4, slave latency 10 → 4 issues, then s_valid=0 and outstanding=4. On the first s_rvalid, the pop occurs and the issue resumes the next cycle.
- s_rvalid pulse with outstanding=0 → no m_rvalid, err_orphan=1 and held.
- Assert rst with 2 outstanding, release, then deliver 2 stale responses → err_orphan=1 and outstanding=0.
